// File: rtl/sound_mixer_dsm_if.sv
// ----------------------------------------------------------------------------
// sound_mixer_dsm_if
// Bundles the sample/volume inputs and the mixed-output signals of
// sound_mixer_dsm.
//   IN       channel samples, channel k at [k*IN_WIDTH +: IN_WIDTH]
//   VOL      channel volumes, channel k at [k*VOL_WIDTH +: VOL_WIDTH]
//   MUTE     forces the mixed result to zero
//   OUT      mixed, saturated sample (two's complement)
//   OUT_STB  one-cycle pulse when OUT updates
//   DSM_OUT  1-bit delta-sigma stream
// master: the sound sources / consumer side; slave: the mixer.
// ----------------------------------------------------------------------------
interface sound_mixer_dsm_if #(
   parameter int CH_COUNT  = 4,
   parameter int IN_WIDTH  = 16,
   parameter int VOL_WIDTH = 4,
   parameter int OUT_WIDTH = 16
);
   logic [CH_COUNT*IN_WIDTH-1:0]  IN;
   logic [CH_COUNT*VOL_WIDTH-1:0] VOL;
   logic                          MUTE;
   logic [OUT_WIDTH-1:0]          OUT;
   logic                          OUT_STB;
   logic                          DSM_OUT;

   modport master (output IN, VOL, MUTE, input OUT, OUT_STB, DSM_OUT);
   modport slave  (input IN, VOL, MUTE, output OUT, OUT_STB, DSM_OUT);
endinterface

// File: rtl/sound_mixer_dsm.sv
// ----------------------------------------------------------------------------
// sound_mixer_dsm
// Mixes CH_COUNT signed channels with per-channel volume through a single
// time-multiplexed MAC, saturates the sum to OUT_WIDTH once every SAMPLE_DIV
// clocks and optionally drives a first-order delta-sigma bitstream.
//
// Ports:
//   CLK      system clock
//   RESET_n  asynchronous active-low reset
//   bus      sound_mixer_dsm_if.slave (IN, VOL, MUTE in; OUT, OUT_STB,
//            DSM_OUT out)
//
// Optional feature: define SOUND_MIXER_DSM_EN to build the delta-sigma
// integrator; otherwise DSM_OUT is tied low.
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for the sample tick
//   MAC    | accumulating one channel per cycle from the snapshot
//   SAT    | shift, clamp, mute and register the output sample
// ----------------------------------------------------------------------------
module sound_mixer_dsm #(
   parameter int CH_COUNT   = 4,
   parameter int IN_WIDTH   = 16,
   parameter int VOL_WIDTH  = 4,
   parameter int OUT_WIDTH  = 16,
   parameter int SAMPLE_DIV = 448
) (
   input  logic              CLK,
   input  logic              RESET_n,
   sound_mixer_dsm_if.slave  bus
);

   localparam int ACC_W = IN_WIDTH + VOL_WIDTH + $clog2(CH_COUNT) + 1;
   localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int IDX_W = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_COUNT - 1);

   localparam longint OUT_MAX = (longint'(1) << (OUT_WIDTH - 1)) - 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(OUT_MAX);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-OUT_MAX - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT} state_t;

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q;
   logic                          tick;
   logic [CH_COUNT*IN_WIDTH-1:0]  in_snap_q;
   logic [CH_COUNT*VOL_WIDTH-1:0] vol_snap_q;
   logic                          mute_snap_q;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic signed [ACC_W-1:0]       acc_q, acc_d;
   logic [OUT_WIDTH-1:0]          out_q, out_d;
   logic                          stb_q, stb_d;

   logic signed [IN_WIDTH-1:0]    in_ch;
   logic [VOL_WIDTH-1:0]          vol_ch;
   logic signed [ACC_W-1:0]       in_ext, vol_ext, prod;
   logic signed [ACC_W-1:0]       shifted;
   logic [OUT_WIDTH-1:0]          sat_val;

   // ---------------- sample-rate divider ----------------
   assign tick = (cnt_q == CNT_LAST);

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) cnt_q <= '0;
      else          cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
   end

   // ---------------- input snapshot ----------------
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         in_snap_q   <= '0;
         vol_snap_q  <= '0;
         mute_snap_q <= 1'b0;
      end else if (tick) begin
         in_snap_q   <= bus.IN;
         vol_snap_q  <= bus.VOL;
         mute_snap_q <= bus.MUTE;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (tick) state_d = S_MAC;
         S_MAC:   if (idx_q == IDX_LAST) state_d = S_SAT;
         S_SAT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- MAC operands ----------------
   // Volume is zero-extended so it stays non-negative in the signed multiply;
   // ACC_W is wide enough that the product and the full sum never wrap.
   always_comb begin
      in_ch   = in_snap_q[int'(idx_q)*IN_WIDTH +: IN_WIDTH];
      vol_ch  = vol_snap_q[int'(idx_q)*VOL_WIDTH +: VOL_WIDTH];
      in_ext  = {{(ACC_W-IN_WIDTH){in_ch[IN_WIDTH-1]}}, in_ch};
      vol_ext = {{(ACC_W-VOL_WIDTH){1'b0}}, vol_ch};
      prod    = in_ext * vol_ext;
   end

   // ---------------- output scaling and clamp ----------------
   always_comb begin
      shifted = acc_q >>> (VOL_WIDTH - 1);
      if (shifted > SAT_MAX)      sat_val = OUT_WIDTH'(SAT_MAX);
      else if (shifted < SAT_MIN) sat_val = OUT_WIDTH'(SAT_MIN);
      else                        sat_val = shifted[OUT_WIDTH-1:0];
   end

   // ---------------- FSM: outputs / datapath next values ----------------
   always_comb begin
      acc_d = acc_q;
      idx_d = idx_q;
      out_d = out_q;
      stb_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               acc_d = '0;
               idx_d = '0;
            end
         end
         S_MAC: begin
            acc_d = acc_q + prod;
            idx_d = idx_q + IDX_W'(1);
         end
         S_SAT: begin
            out_d = mute_snap_q ? '0 : sat_val;
            stb_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         acc_q <= '0;
         idx_q <= '0;
         out_q <= '0;
         stb_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
         out_q <= out_d;
         stb_q <= stb_d;
      end
   end

   assign bus.OUT     = out_q;
   assign bus.OUT_STB = stb_q;

   // ---------------- delta-sigma modulator ----------------
`ifdef SOUND_MIXER_DSM_EN
   logic [OUT_WIDTH-1:0] dsm_u;
   logic [OUT_WIDTH:0]   integ_q, integ_d;

   // Offset-binary input: flipping the MSB maps -2^(N-1)..2^(N-1)-1 to 0..2^N-1.
   assign dsm_u   = {~out_q[OUT_WIDTH-1], out_q[OUT_WIDTH-2:0]};
   assign integ_d = {1'b0, integ_q[OUT_WIDTH-1:0]} + {1'b0, dsm_u};

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) integ_q <= '0;
      else          integ_q <= integ_d;
   end

   assign bus.DSM_OUT = integ_q[OUT_WIDTH];
`else
   assign bus.DSM_OUT = 1'b0;
`endif

endmodule
